// File: rtl/pe_ctrl_serial.sv
// Control sequencer for the bit-serial PE array: weight load, K serial MACs, drain, done.
// Optional weight-reuse port enabled by defining PE_CTRL_WREUSE_EN.
module pe_ctrl_serial #(
    parameter int unsigned IDEPTH    = 4,
    parameter int unsigned MUL_CYC   = 16,
    parameter int unsigned KW        = 8,
    parameter int unsigned DRAIN_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef PE_CTRL_WREUSE_EN
    input  logic              reuse_w,
`endif
    input  logic [KW-1:0]     k_len,
    input  logic              stall,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [IDEPTH-1:0] idx,
    output logic              mac_done,
    output logic              en_i,
    output logic              clr_i,
    output logic              en_w,
    output logic              clr_w,
    output logic              en_o,
    output logic              clr_o
);

    localparam int unsigned      DW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IDEPTH-1:0] BitLast  = IDEPTH'(MUL_CYC - 1);
    localparam logic [DW-1:0]    DrainLast = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {StIdle, StLoadW, StMac, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDEPTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [KW-1:0]     mac_cnt_q, mac_cnt_d;
    logic [KW-1:0]     k_len_q, k_len_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;

    logic skip_load;
    logic kill;
    logic bit_last;
    logic mac_last;
    logic mac_run;

`ifdef PE_CTRL_WREUSE_EN
    assign skip_load = reuse_w;
`else
    assign skip_load = 1'b0;
`endif

    assign kill     = abort & (state_q != StIdle);
    assign bit_last = (bit_cnt_q == BitLast);
    assign mac_last = (mac_cnt_q == (k_len_q - KW'(1)));
    // A MAC cycle that actually advances the serial sequence.
    assign mac_run  = (state_q == StMac) & ~stall & ~abort;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        mac_cnt_d   = mac_cnt_q;
        k_len_d     = k_len_q;
        drain_cnt_d = drain_cnt_q;
        if (kill) begin
            state_d     = StIdle;
            bit_cnt_d   = '0;
            mac_cnt_d   = '0;
            k_len_d     = '0;
            drain_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        k_len_d = k_len;
                        if (k_len == '0) begin
                            state_d = StDone;
                        end else if (skip_load) begin
                            state_d = StMac;
                        end else begin
                            state_d = StLoadW;
                        end
                    end
                end
                StLoadW: state_d = StMac;
                StMac: begin
                    if (!stall) begin
                        if (bit_last) begin
                            bit_cnt_d = '0;
                            if (mac_last) begin
                                mac_cnt_d = '0;
                                state_d   = StDrain;
                            end else begin
                                mac_cnt_d = mac_cnt_q + KW'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + IDEPTH'(1);
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainLast) begin
                        drain_cnt_d = '0;
                        state_d     = StDone;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            mac_cnt_q   <= '0;
            k_len_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            mac_cnt_q   <= mac_cnt_d;
            k_len_q     <= k_len_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Only stall and abort reach the outputs combinationally.
    always_comb begin
        ready    = (state_q == StIdle);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone) & ~kill;
        idx      = bit_cnt_q;
        en_w     = (state_q == StLoadW) & ~kill;
        en_o     = mac_run;
        en_i     = mac_run & (bit_cnt_q == '0);
        mac_done = mac_run & bit_last;
        clr_o    = (mac_run & (bit_cnt_q == '0) & (mac_cnt_q == '0)) | kill;
        clr_i    = kill;
        clr_w    = kill;
    end

endmodule

// File: tb/tb_pe_ctrl_serial.sv
// Self-checking bench for pe_ctrl_serial: timeline-based reference model plus directed
// literal checks, then randomized start/stall/abort traffic.
module tb_pe_ctrl_serial;

    localparam int M = 16;
    localparam int D = 3;
`ifdef PE_CTRL_WREUSE_EN
    localparam bit ReuseEn = 1'b1;
`else
    localparam bit ReuseEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       reuse_w = 1'b0;
    logic [7:0] k_len = '0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic       ready, busy, done, mac_done;
    logic [3:0] idx;
    logic       en_i, clr_i, en_w, clr_w, en_o, clr_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_ctrl_serial #(
        .IDEPTH   (4),
        .MUL_CYC  (M),
        .KW       (8),
        .DRAIN_CYC(D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef PE_CTRL_WREUSE_EN
        .reuse_w (reuse_w),
`endif
        .k_len   (k_len),
        .stall   (stall),
        .abort   (abort),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .idx     (idx),
        .mac_done(mac_done),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .en_w    (en_w),
        .clr_w   (clr_w),
        .en_o    (en_o),
        .clr_o   (clr_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a tile is a timeline of progress steps t (stalled MAC cycles don't advance t).
    bit m_act = 1'b0;
    int m_k = 0;
    bit m_reuse = 1'b0;
    int m_t = 0;

    function automatic int mac_pos();
        return m_t - (m_reuse ? 0 : 1);
    endfunction

    // 0 idle, 1 load, 2 mac, 3 drain, 4 done
    function automatic int ph_now();
        int p;
        if (!m_act) return 0;
        if (m_k == 0) return 4;
        if (!m_reuse && m_t == 0) return 1;
        p = mac_pos();
        if (p < m_k * M) return 2;
        if (p < m_k * M + D) return 3;
        return 4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act   <= 1'b1;
                m_k     <= int'(k_len);
                m_reuse <= ReuseEn & reuse_w;
                m_t     <= 0;
            end
        end else if (abort || ph_now() == 4) begin
            m_act <= 1'b0;
        end else if (!(ph_now() == 2 && stall)) begin
            m_t <= m_t + 1;
        end
    end

    task automatic compare_all();
        int ph, b, mc;
        bit run, kl;
        ph  = ph_now();
        b   = (ph == 2) ? mac_pos() % M : 0;
        mc  = (ph == 2) ? mac_pos() / M : 0;
        run = (ph == 2) && !stall && !abort;
        kl  = (ph != 0) && abort;
        chk("ready", int'(ready), int'(ph == 0));
        chk("busy", int'(busy), int'(ph != 0));
        chk("done", int'(done), int'(ph == 4 && !abort));
        chk("idx", int'(idx), b);
        chk("en_w", int'(en_w), int'(ph == 1 && !abort));
        chk("en_o", int'(en_o), int'(run));
        chk("en_i", int'(en_i), int'(run && b == 0));
        chk("mac_done", int'(mac_done), int'(run && b == M - 1));
        chk("clr_o", int'(clr_o), int'((run && b == 0 && mc == 0) || kl));
        chk("clr_i", int'(clr_i), int'(kl));
        chk("clr_w", int'(clr_w), int'(kl));
    endtask

    always @(negedge clk) begin
        if (rst_n) compare_all();
    end

    logic [63:0] l_done, l_md, l_enw, l_eni, l_eno, l_clro, l_clri, l_clrw, l_rdy, l_busy;
    logic [3:0]  l_idx [64];

    // Called in IDLE just after a rising edge; log entry i is cycle T+i.
    task automatic run_tile(input int k, input bit ru, input int st_lo, input int st_hi,
                            input int ab_at, input int busy_at, input int n);
        start = 1'b1; k_len = 8'(k); reuse_w = ru;
        @(posedge clk); #1;
        start = 1'b0; reuse_w = 1'b0;
        l_done = '0; l_md = '0; l_enw = '0; l_eni = '0; l_eno = '0;
        l_clro = '0; l_clri = '0; l_clrw = '0; l_rdy = '0; l_busy = '0;
        for (int i = 1; i <= n; i++) begin
            stall = (i >= st_lo && i <= st_hi);
            abort = (i == ab_at);
            start = (i == busy_at);
            if (i == busy_at) k_len = 8'd3;
            @(negedge clk);
            l_done[i] = done; l_md[i] = mac_done; l_enw[i] = en_w; l_eni[i] = en_i;
            l_eno[i] = en_o; l_clro[i] = clr_o; l_clri[i] = clr_i; l_clrw[i] = clr_w;
            l_rdy[i] = ready; l_busy[i] = busy; l_idx[i] = idx;
            @(posedge clk); #1;
        end
        stall = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_en", int'(en_i | en_w | en_o | mac_done | done), 0);
        chk("rst_clr", int'(clr_i | clr_w | clr_o), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_tile(2, 1'b0, 0, -1, 0, 0, 40);
        chk("a_enw_t1", int'(l_enw[1]), 1);
        chk("a_eni_t2", int'(l_eni[2]), 1);
        chk("a_clro_t2", int'(l_clro[2]), 1);
        chk("a_md_t16", int'(l_md[16]), 0);
        chk("a_md_t17", int'(l_md[17]), 1);
        chk("a_clro_t18", int'(l_clro[18]), 0);
        chk("a_md_t33", int'(l_md[33]), 1);
        chk("a_done_t36", int'(l_done[36]), 0);
        chk("a_done_t37", int'(l_done[37]), 1);
        chk("a_ready_t38", int'(l_rdy[38]), 1);

        run_tile(0, 1'b0, 0, -1, 0, 0, 4);
        chk("z_done_t1", int'(l_done[1]), 1);
        chk("z_busy_t1", int'(l_busy[1]), 1);
        chk("z_ready_t2", int'(l_rdy[2]), 1);
        chk("z_en", int'(|(l_enw | l_eni | l_eno)), 0);

        run_tile(1, 1'b0, 7, 9, 0, 0, 30);
        chk("s_idx_t7", int'(l_idx[7]), 5);
        chk("s_idx_t9", int'(l_idx[9]), 5);
        chk("s_idx_t11", int'(l_idx[11]), 6);
        chk("s_eno_t8", int'(l_eno[8]), 0);
        chk("s_eno_t10", int'(l_eno[10]), 1);
        chk("s_done_t21", int'(l_done[21]), 0);
        chk("s_done_t24", int'(l_done[24]), 1);

        run_tile(2, 1'b0, 0, -1, 25, 0, 30);
        chk("ab_idx_t25", int'(l_idx[25]), 7);
        chk("ab_clr_t25", int'(l_clri[25] & l_clrw[25] & l_clro[25]), 1);
        chk("ab_eno_t25", int'(l_eno[25]), 0);
        chk("ab_clr_t26", int'(l_clri[26]), 0);
        chk("ab_ready_t26", int'(l_rdy[26]), 1);
        chk("ab_no_done", int'(|l_done), 0);

        run_tile(1, 1'b0, 0, -1, 0, 5, 24);
        chk("bz_done_t21", int'(l_done[21]), 1);
        chk("bz_busy_t23", int'(l_busy[23]), 0);
        run_tile(1, 1'b0, 0, -1, 0, 0, 24);
        chk("bz2_enw_t1", int'(l_enw[1]), 1);
        chk("bz2_done_t21", int'(l_done[21]), 1);

`ifdef PE_CTRL_WREUSE_EN
        run_tile(1, 1'b1, 0, -1, 0, 0, 24);
        chk("ru_enw_t1", int'(l_enw[1]), 0);
        chk("ru_eni_t1", int'(l_eni[1]), 1);
        chk("ru_done_t20", int'(l_done[20]), 1);
`endif

        // Asynchronous reset in the middle of a tile.
        start = 1'b1; k_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ready", int'(ready), 1);
        chk("mr_busy", int'(busy), 0);
        chk("mr_idx", int'(idx), 0);
        chk("mr_en", int'(en_o | en_i | mac_done), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom % 6) == 0;
            k_len   = 8'($urandom_range(0, 3));
            stall   = ($urandom % 4) == 0;
            abort   = ($urandom % 80) == 0;
            reuse_w = $urandom % 2;
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; abort = 1'b0; reuse_w = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
